// File: rtl/rng_word_reader_pkg.sv
// Shared types and defaults for the RNG word reader.
// FSM state encoding and default sample/word/timeout sizes.
package rng_word_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_SPLIT = 2'd3
  } state_e;

  localparam int DEF_NBITS   = 256;
  localparam int DEF_WBITS   = 32;
  localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/rng_word_serializer.sv
// Splits one NBITS sample into NBITS/WBITS words, LSW first.
// Ports: load/din in, word_o/word_valid/word_ready/last_o, xfer_last.
module rng_word_serializer
  import rng_word_reader_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int WBITS = DEF_WBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [NBITS-1:0] din,
  output logic [WBITS-1:0] word_o,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             last_o,
  output logic             xfer_last
);

  localparam int NW = NBITS / WBITS;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic             valid_q, valid_d;
  logic             hs;

  assign word_o     = shreg_q[WBITS-1:0];
  assign word_valid = valid_q;
  assign last_o     = valid_q && (wcnt_q == CW'(NW - 1));
  assign hs         = valid_q && word_ready;
  assign xfer_last  = hs && last_o;

  always_comb begin
    shreg_d = shreg_q;
    wcnt_d  = wcnt_q;
    valid_d = valid_q;
    if (load) begin
      shreg_d = din;
      wcnt_d  = '0;
      valid_d = 1'b1;
    end else if (hs) begin
      shreg_d = shreg_q >> WBITS;
      if (last_o) begin
        wcnt_d  = '0;
        valid_d = 1'b0;
      end else begin
        wcnt_d = wcnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      wcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      wcnt_q  <= wcnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/rng_word_reader.sv
// Requests samples from an RNG, rejects repeats/timeouts, emits words.
// Ports: start/enable_p/y/done_p, word stream, rep_err/tout_err/clr_err.
module rng_word_reader
  import rng_word_reader_pkg::*;
#(
  parameter int NBITS   = DEF_NBITS,
  parameter int WBITS   = DEF_WBITS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             enable_p,
  input  logic [NBITS-1:0] y,
  input  logic             done_p,
  output logic [WBITS-1:0] word_o,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             last_o,
  output logic             rep_err,
  output logic             tout_err,
  input  logic             clr_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [NBITS-1:0] prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic             rep_err_q, rep_err_d;
  logic             tout_err_q, tout_err_d;
  logic             enable_q, enable_d;

  logic is_rep;
  logic t_hit;
  logic in_wait;
  logic ser_load;
  logic rep_set;
  logic tout_set;
  logic ser_xfer_last;

  assign in_wait  = (state_q == S_WAIT);
  assign is_rep   = prev_vld_q && (y == prev_q);
  assign t_hit    = (tcnt_q == TW'(TIMEOUT - 1));
  assign enable_p = enable_q;
  assign rep_err  = rep_err_q;
  assign tout_err = tout_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !rep_err_q && !tout_err_q) begin
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        // done_p beats a timeout landing in the same cycle
        if (done_p) begin
          state_d = is_rep ? S_IDLE : S_SPLIT;
        end else if (t_hit) begin
          state_d = S_IDLE;
        end
      end
      S_SPLIT: begin
        if (ser_xfer_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ser_load = in_wait && done_p && !is_rep;
    rep_set  = in_wait && done_p && is_rep;
    tout_set = in_wait && !done_p && t_hit;

    tcnt_d = '0;
    if (in_wait && !done_p && !t_hit) begin
      tcnt_d = tcnt_q + TW'(1);
    end

    prev_d     = ser_load ? y : prev_q;
    prev_vld_d = ser_load ? 1'b1 : prev_vld_q;

    // set has priority over clear
    rep_err_d = rep_err_q;
    if (rep_set) begin
      rep_err_d = 1'b1;
    end else if (clr_err) begin
      rep_err_d = 1'b0;
    end

    tout_err_d = tout_err_q;
    if (tout_set) begin
      tout_err_d = 1'b1;
    end else if (clr_err) begin
      tout_err_d = 1'b0;
    end

    enable_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q     <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      rep_err_q  <= 1'b0;
      tout_err_q <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      tcnt_q     <= tcnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      rep_err_q  <= rep_err_d;
      tout_err_q <= tout_err_d;
      enable_q   <= enable_d;
    end
  end

  rng_word_serializer #(
    .NBITS (NBITS),
    .WBITS (WBITS)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ser_load),
    .din        (y),
    .word_o     (word_o),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .last_o     (last_o),
    .xfer_last  (ser_xfer_last)
  );

endmodule

// File: tb/tb_rng_word_reader.sv
// Directed bench for rng_word_reader (256/32, TIMEOUT=16).
// Plays the generator and the downstream sink.
module tb_rng_word_reader;
  import rng_word_reader_pkg::*;

  localparam int NB = DEF_NBITS;
  localparam int WB = DEF_WBITS;
  localparam int NW = NB / WB;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          done_p = 1'b0;
  logic          word_ready = 1'b0;
  logic          clr_err = 1'b0;
  logic [NB-1:0] y = '0;
  logic          enable_p;
  logic [WB-1:0] word_o;
  logic          word_valid;
  logic          last_o;
  logic          rep_err;
  logic          tout_err;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;

  rng_word_reader #(
    .NBITS   (NB),
    .WBITS   (WB),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .enable_p   (enable_p),
    .y          (y),
    .done_p     (done_p),
    .word_o     (word_o),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .last_o     (last_o),
    .rep_err    (rep_err),
    .tout_err   (tout_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (enable_p) en_cnt++;

  function automatic logic [NB-1:0] mk(input logic [31:0] base);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r[WB*i +: WB] = base + 32'(i);
    return r;
  endfunction

  task automatic wait_en(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!enable_p && n < 40);
  endtask

  task automatic pulse_done(input logic [NB-1:0] v);
    done_p = 1'b1;
    y = v;
    @(negedge clk);
    done_p = 1'b0;
    y = '0;
  endtask

  task automatic drain(input logic [NB-1:0] v, output int good);
    logic [WB-1:0] e;
    good = 0;
    word_ready = 1'b1;
    for (int k = 0; k < NW; k++) begin
      e = v[WB*k +: WB];
      if (word_valid && word_o === e && last_o === (k == NW - 1)) good++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if (enable_p !== 1'b0) begin
      errors++; $display("FAIL reset_enable: got %b want 0", enable_p);
    end
    checks++;
    if (word_valid !== 1'b0 || last_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid_last: got %b%b want 00", word_valid, last_o);
    end
    checks++;
    if (rep_err !== 1'b0 || tout_err !== 1'b0) begin
      errors++; $display("FAIL reset_errs: got %b%b want 00", rep_err, tout_err);
    end
    checks++;
    if (word_o !== '0) begin
      errors++; $display("FAIL reset_word: got %h want 0", word_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (en_cnt !== 0) begin
      errors++; $display("FAIL idle_no_req: got %0d want 0", en_cnt);
    end
  endtask

  task automatic test_basic;
    int n, good, e0;
    logic [NB-1:0] v;
    v = mk(32'd1);
    word_ready = 1'b1;
    e0 = en_cnt;
    start = 1'b1;
    wait_en(n);
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL turnaround: got %0d want 1", n);
    end
    start = 1'b0;
    @(negedge clk);
    pulse_done(v);
    drain(v, good);
    checks++;
    if (good !== NW) begin
      errors++; $display("FAIL basic_words: got %0d want %0d", good, NW);
    end
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL basic_end_valid: got %b want 0", word_valid);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (en_cnt - e0 !== 1) begin
      errors++; $display("FAIL basic_enable_count: got %0d want 1", en_cnt - e0);
    end
  endtask

  task automatic test_stall;
    int n, cyc, good, bad;
    logic [NB-1:0] v;
    logic [WB-1:0] held;
    logic [WB-1:0] e;
    int idx;
    v = mk(32'h1000_0000);
    start = 1'b1;
    wait_en(n);
    start = 1'b0;
    word_ready = 1'b0;
    @(negedge clk);
    pulse_done(v);
    cyc = 0; good = 0; bad = 0; idx = 0; held = '0;
    while (word_valid && cyc < 40) begin
      if (cyc % 2 == 1 && word_o !== held) bad++;
      word_ready = (cyc % 2 == 1);
      if (cyc % 2 == 0) begin
        held = word_o;
      end else begin
        e = v[WB*idx +: WB];
        if (word_o === e) good++;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    word_ready = 1'b1;
    checks++;
    if (cyc !== 2 * NW) begin
      errors++; $display("FAIL stall_cycles: got %0d want %0d", cyc, 2 * NW);
    end
    checks++;
    if (good !== NW) begin
      errors++; $display("FAIL stall_words: got %0d want %0d", good, NW);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL stall_stable: got %0d changes want 0", bad);
    end
  endtask

  task automatic test_repeat;
    int n, good, e1, seen;
    logic [NB-1:0] v5;
    v5 = 256'd5;
    word_ready = 1'b1;
    start = 1'b1;
    wait_en(n);
    @(negedge clk);
    pulse_done(v5);
    drain(v5, good);
    checks++;
    if (good !== NW) begin
      errors++; $display("FAIL rep_first_words: got %0d want %0d", good, NW);
    end
    wait_en(n);
    checks++;
    if (enable_p !== 1'b1) begin
      errors++; $display("FAIL rep_second_req: got %b want 1", enable_p);
    end
    @(negedge clk);
    pulse_done(v5);
    checks++;
    if (rep_err !== 1'b1 || word_valid !== 1'b0) begin
      errors++; $display("FAIL rep_flag: got err=%b valid=%b want 1 0", rep_err, word_valid);
    end
    e1 = en_cnt;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (word_valid) seen++;
    end
    checks++;
    if (en_cnt !== e1 || seen !== 0) begin
      errors++; $display("FAIL rep_blocked: got req=%0d words=%0d want 0 0", en_cnt - e1, seen);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (rep_err !== 1'b0) begin
      errors++; $display("FAIL rep_clear: got %b want 0", rep_err);
    end
    wait_en(n);
    checks++;
    if (enable_p !== 1'b1) begin
      errors++; $display("FAIL rep_resume: got %b want 1", enable_p);
    end
    start = 1'b0;
    @(negedge clk);
    pulse_done(mk(32'h5500_0000));
    drain(mk(32'h5500_0000), good);
    checks++;
    if (good !== NW) begin
      errors++; $display("FAIL rep_resume_words: got %0d want %0d", good, NW);
    end
  endtask

  task automatic test_timeout;
    int n, good;
    logic [NB-1:0] v;
    v = mk(32'h3000_0000);
    start = 1'b1;
    wait_en(n);
    start = 1'b0;
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      if (k == TO) begin
        checks++;
        if (tout_err !== 1'b0) begin
          errors++; $display("FAIL tout_early: got %b want 0", tout_err);
        end
      end
      if (k == TO + 1) begin
        checks++;
        if (tout_err !== 1'b1) begin
          errors++; $display("FAIL tout_set: got %b want 1", tout_err);
        end
      end
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (tout_err !== 1'b0) begin
      errors++; $display("FAIL tout_clear: got %b want 0", tout_err);
    end
    start = 1'b1;
    wait_en(n);
    start = 1'b0;
    repeat (TO) @(negedge clk);
    pulse_done(v);
    checks++;
    if (tout_err !== 1'b0 || word_valid !== 1'b1) begin
      errors++; $display("FAIL tout_late_done: got err=%b valid=%b want 0 1", tout_err, word_valid);
    end
    drain(v, good);
    checks++;
    if (good !== NW || tout_err !== 1'b0) begin
      errors++; $display("FAIL tout_late_words: got %0d err=%b want %0d 0", good, tout_err, NW);
    end
  endtask

  task automatic test_reset_mid;
    int n, good;
    logic [NB-1:0] v;
    logic [WB-1:0] e;
    v = mk(32'h4000_0000);
    e = v[WB*2 +: WB];
    word_ready = 1'b1;
    start = 1'b1;
    wait_en(n);
    start = 1'b0;
    @(negedge clk);
    pulse_done(v);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (word_o !== e) begin
      errors++; $display("FAIL mid_word3: got %h want %h", word_o, e);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (word_valid !== 1'b0 || word_o !== '0 || last_o !== 1'b0) begin
      errors++; $display("FAIL mid_async: got valid=%b word=%h last=%b want 0", word_valid, word_o, last_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    wait_en(n);
    start = 1'b0;
    @(negedge clk);
    pulse_done(v);
    checks++;
    if (rep_err !== 1'b0 || word_valid !== 1'b1) begin
      errors++; $display("FAIL mid_no_rep: got err=%b valid=%b want 0 1", rep_err, word_valid);
    end
    drain(v, good);
    checks++;
    if (good !== NW) begin
      errors++; $display("FAIL mid_words: got %0d want %0d", good, NW);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_repeat;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
